// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB-to-memory bridge.
// The counter width covers the whole legal read-latency range (1..4).
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } apb_state_t;

    localparam int RD_LATENCY_MAX = 4;
    localparam int RD_CNT_W       = $clog2(RD_LATENCY_MAX + 1);

    function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/apb_wait_counter.sv
// Loadable down-counter used to time memory read latency.
// zero_next flags that the current decrement takes the count to zero.
module apb_wait_counter
    import apb_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                dec,
    input  logic [RD_CNT_W-1:0] load_val,
    output logic                zero_next
);

    logic [RD_CNT_W-1:0] count_reg;
    logic [RD_CNT_W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (load) begin
            count_next = load_val;
        end else if (dec && (count_reg != '0)) begin
            count_next = count_reg - RD_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign zero_next = (count_reg == RD_CNT_W'(1));

endmodule

// File: rtl/apb_mem_bridge.sv
// APB3 completer that turns each transfer into one memory access,
// inserting read wait states and flagging out-of-range addresses.
module apb_mem_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 14,
    parameter int MEM_DEPTH  = 16,
    parameter int RD_LATENCY = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_psel,
    input  logic                  i_penable,
    input  logic                  i_pwrite,
    input  logic [ADDR_WIDTH-1:0] i_paddr,
    input  logic [DATA_WIDTH-1:0] i_pwdata,
    output logic [DATA_WIDTH-1:0] o_prdata,
    output logic                  o_pready,
    output logic                  o_pslverr,
    output logic                  o_mem_en,
    output logic                  o_mem_wr,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [ADDR_WIDTH-1:0] o_mem_write_addr,
    output logic [DATA_WIDTH-1:0] o_mem_data_w,
    input  logic [DATA_WIDTH-1:0] i_mem_data_r
);

    apb_state_t state_reg, state_next;

    logic [DATA_WIDTH-1:0] prdata_reg, prdata_next;
    logic                  pready_reg, pready_next;
    logic                  pslverr_reg, pslverr_next;
    logic                  mem_en_reg, mem_en_next;
    logic                  mem_wr_reg, mem_wr_next;
    logic [ADDR_WIDTH-1:0] mem_addr_reg, mem_addr_next;
    logic [DATA_WIDTH-1:0] mem_data_w_reg, mem_data_w_next;

    logic cnt_load;
    logic cnt_dec;
    logic cnt_zero_next;

    apb_wait_counter u_wait_counter (
        .clk       (i_clk),
        .rst       (i_rst),
        .load      (cnt_load),
        .dec       (cnt_dec),
        .load_val  (RD_CNT_W'(RD_LATENCY)),
        .zero_next (cnt_zero_next)
    );

    // The setup-phase address/data/direction are captured straight into the
    // strobe output registers, so those registers double as the latched request.
    always_comb begin
        state_next      = state_reg;
        prdata_next     = prdata_reg;
        pready_next     = 1'b0;
        pslverr_next    = 1'b0;
        mem_en_next     = 1'b0;
        mem_wr_next     = 1'b0;
        mem_addr_next   = '0;
        mem_data_w_next = '0;
        cnt_load        = 1'b0;
        cnt_dec         = 1'b0;

        case (state_reg)
            IDLE: begin
                if (i_psel && !i_penable) begin
                    if (!addr_in_range(32'(i_paddr), MEM_DEPTH)) begin
                        state_next   = RESP;
                        pready_next  = 1'b1;
                        pslverr_next = 1'b1;
                        prdata_next  = '0;
                    end else begin
                        state_next      = STROBE;
                        mem_en_next     = 1'b1;
                        mem_wr_next     = i_pwrite;
                        mem_addr_next   = i_paddr;
                        mem_data_w_next = i_pwrite ? i_pwdata : '0;
                    end
                end
            end
            STROBE: begin
                // mem_wr_reg still holds the latched direction during the strobe.
                if (!i_psel) begin
                    state_next = IDLE;
                end else if (mem_wr_reg) begin
                    state_next  = RESP;
                    pready_next = 1'b1;
                end else begin
                    state_next = WAIT;
                    cnt_load   = 1'b1;
                end
            end
            WAIT: begin
                if (!i_psel) begin
                    state_next = IDLE;
                end else begin
                    cnt_dec = 1'b1;
                    if (cnt_zero_next) begin
                        state_next  = RESP;
                        pready_next = 1'b1;
                        prdata_next = i_mem_data_r;
                    end
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg      <= IDLE;
            prdata_reg     <= '0;
            pready_reg     <= 1'b0;
            pslverr_reg    <= 1'b0;
            mem_en_reg     <= 1'b0;
            mem_wr_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_data_w_reg <= '0;
        end else begin
            state_reg      <= state_next;
            prdata_reg     <= prdata_next;
            pready_reg     <= pready_next;
            pslverr_reg    <= pslverr_next;
            mem_en_reg     <= mem_en_next;
            mem_wr_reg     <= mem_wr_next;
            mem_addr_reg   <= mem_addr_next;
            mem_data_w_reg <= mem_data_w_next;
        end
    end

    assign o_prdata         = prdata_reg;
    assign o_pready         = pready_reg;
    assign o_pslverr        = pslverr_reg;
    assign o_mem_en         = mem_en_reg;
    assign o_mem_wr         = mem_wr_reg;
    assign o_mem_addr       = mem_addr_reg;
    assign o_mem_write_addr = mem_addr_reg;
    assign o_mem_data_w     = mem_data_w_reg;

endmodule

// File: tb/tb_apb_mem_bridge.sv
// Directed bench: bridge A (MEM_DEPTH=15, RD_LATENCY=1) and bridge B
// (MEM_DEPTH=16, RD_LATENCY=3), each with its own memory model.
module tb_apb_mem_bridge;

    localparam int AW = 4;
    localparam int DW = 14;
    localparam logic [DW-1:0] JUNK = 14'h1DEA;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_a, rst_b, psel_a, psel_b, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;

    logic [DW-1:0] prdata_a, prdata_b, mem_dw_a, mem_dw_b, mem_rd_a, mem_rd_b;
    logic          pready_a, pready_b, pslverr_a, pslverr_b;
    logic          mem_en_a, mem_en_b, mem_wr_a, mem_wr_b;
    logic [AW-1:0] mem_addr_a, mem_addr_b, mem_waddr_a, mem_waddr_b;

    apb_mem_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(15), .RD_LATENCY(1)) u_dut_a (
        .i_clk(clk), .i_rst(rst_a), .i_psel(psel_a), .i_penable(penable), .i_pwrite(pwrite),
        .i_paddr(paddr), .i_pwdata(pwdata), .o_prdata(prdata_a), .o_pready(pready_a),
        .o_pslverr(pslverr_a), .o_mem_en(mem_en_a), .o_mem_wr(mem_wr_a), .o_mem_addr(mem_addr_a),
        .o_mem_write_addr(mem_waddr_a), .o_mem_data_w(mem_dw_a), .i_mem_data_r(mem_rd_a)
    );

    apb_mem_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(16), .RD_LATENCY(3)) u_dut_b (
        .i_clk(clk), .i_rst(rst_b), .i_psel(psel_b), .i_penable(penable), .i_pwrite(pwrite),
        .i_paddr(paddr), .i_pwdata(pwdata), .o_prdata(prdata_b), .o_pready(pready_b),
        .o_pslverr(pslverr_b), .o_mem_en(mem_en_b), .o_mem_wr(mem_wr_b), .o_mem_addr(mem_addr_b),
        .o_mem_write_addr(mem_waddr_b), .o_mem_data_w(mem_dw_b), .i_mem_data_r(mem_rd_b)
    );

    // Memory models: synchronous write, read data valid RD_LATENCY cycles after the strobe.
    logic [DW-1:0] mem_a [16];
    logic [DW-1:0] mem_b [16];
    logic [DW-1:0] pipe_a;
    logic [DW-1:0] pipe_b [3];

    always @(posedge clk) begin
        if (mem_en_a && mem_wr_a) mem_a[mem_waddr_a] <= mem_dw_a;
        pipe_a <= (mem_en_a && !mem_wr_a) ? mem_a[mem_addr_a] : JUNK;
        if (mem_en_b && mem_wr_b) mem_b[mem_waddr_b] <= mem_dw_b;
        pipe_b[0] <= (mem_en_b && !mem_wr_b) ? mem_b[mem_addr_b] : JUNK;
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign mem_rd_a = pipe_a;
    assign mem_rd_b = pipe_b[2];

    typedef struct packed {
        logic          pready;
        logic          pslverr;
        logic [DW-1:0] prdata;
        logic          mem_en;
        logic          mem_wr;
        logic [AW-1:0] mem_addr;
        logic [AW-1:0] mem_waddr;
        logic [DW-1:0] mem_dw;
    } obs_t;

    typedef struct {
        int            dut;
        logic          b2b;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            exp_lat;
        logic          exp_err;
        logic [DW-1:0] exp_rdata;
        int            exp_strobes;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic obs_t observe(input int d);
        obs_t o;
        if (d == 0) begin
            o.pready = pready_a; o.pslverr = pslverr_a; o.prdata = prdata_a; o.mem_en = mem_en_a;
            o.mem_wr = mem_wr_a; o.mem_addr = mem_addr_a; o.mem_waddr = mem_waddr_a; o.mem_dw = mem_dw_a;
        end else begin
            o.pready = pready_b; o.pslverr = pslverr_b; o.prdata = prdata_b; o.mem_en = mem_en_b;
            o.mem_wr = mem_wr_b; o.mem_addr = mem_addr_b; o.mem_waddr = mem_waddr_b; o.mem_dw = mem_dw_b;
        end
        return o;
    endfunction

    task automatic set_psel(input int d, input logic v);
        if (d == 0) psel_a = v; else psel_b = v;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // One APB transfer starting now (just after a rising edge). Access-phase
    // inputs are scrambled to prove the setup-phase values are the ones used.
    // drop_at>0 deasserts psel in that access cycle. lat=0 means no PREADY seen.
    task automatic xfer(input int d, input logic wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input int drop_at,
                        output int lat, output obs_t resp, output int strobes,
                        output obs_t strobe_obs, output int strobe_cyc);
        obs_t o;
        lat = 0; strobes = 0; strobe_cyc = 0; resp = '0; strobe_obs = '0;
        set_psel(d, 1'b1); penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
        @(negedge clk);
        o = observe(d);
        if (o.mem_en) strobes++;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            @(posedge clk); #1;
            if (k == drop_at) begin
                set_psel(d, 1'b0); penable = 1'b0;
            end else if (drop_at == 0 || k < drop_at) begin
                penable = 1'b1; pwrite = ~wr; paddr = ~addr; pwdata = ~wdata;
            end
            @(negedge clk);
            o = observe(d);
            if (o.mem_en) begin strobes++; strobe_obs = o; strobe_cyc = k; end
            if (o.pready) begin lat = k; resp = o; end
        end
        @(posedge clk); #1;
        set_psel(d, 1'b0); penable = 1'b0;
    endtask

    vec_t vecs [13];
    int   lat, strobes, strobe_cyc, pready_seen;
    obs_t resp, so, o;
    string tag;

    initial begin
        vecs[0]  = '{0, 1'b0, 1'b1, 4'd3,  14'h152A, 2, 1'b0, 14'h0000, 1};
        vecs[1]  = '{0, 1'b0, 1'b0, 4'd3,  14'h0000, 3, 1'b0, 14'h152A, 1};
        vecs[2]  = '{0, 1'b0, 1'b0, 4'd15, 14'h0000, 1, 1'b1, 14'h0000, 0};
        vecs[3]  = '{0, 1'b0, 1'b0, 4'd3,  14'h0000, 3, 1'b0, 14'h152A, 1};
        vecs[4]  = '{0, 1'b0, 1'b1, 4'd14, 14'h2ABC, 2, 1'b0, 14'h152A, 1};
        vecs[5]  = '{0, 1'b0, 1'b0, 4'd14, 14'h0000, 3, 1'b0, 14'h2ABC, 1};
        vecs[6]  = '{0, 1'b0, 1'b1, 4'd15, 14'h1111, 1, 1'b1, 14'h0000, 0};
        vecs[7]  = '{0, 1'b0, 1'b1, 4'd1,  14'h0001, 2, 1'b0, 14'h0000, 1};
        vecs[8]  = '{0, 1'b1, 1'b0, 4'd1,  14'h0000, 3, 1'b0, 14'h0001, 1};
        vecs[9]  = '{0, 1'b1, 1'b1, 4'd0,  14'h3FFF, 2, 1'b0, 14'h0001, 1};
        vecs[10] = '{0, 1'b1, 1'b0, 4'd0,  14'h0000, 3, 1'b0, 14'h3FFF, 1};
        vecs[11] = '{1, 1'b0, 1'b1, 4'd15, 14'h0ABC, 2, 1'b0, 14'h0000, 1};
        vecs[12] = '{1, 1'b0, 1'b0, 4'd15, 14'h0000, 5, 1'b0, 14'h0ABC, 1};

        rst_a = 1'b1; rst_b = 1'b1; psel_a = 1'b0; psel_b = 1'b0;
        penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            o = observe(d);
            check($sformatf("reset dut%0d pready", d), 32'(o.pready), 0);
            check($sformatf("reset dut%0d mem_en", d), 32'(o.mem_en), 0);
            check($sformatf("reset dut%0d outputs", d), 32'(o), 0);
        end
        @(posedge clk); #1;
        rst_a = 1'b0; rst_b = 1'b0;
        tick();

        for (int i = 0; i < 13; i++) begin
            if (!vecs[i].b2b) tick();
            xfer(vecs[i].dut, vecs[i].wr, vecs[i].addr, vecs[i].wdata, 0, lat, resp, strobes, so, strobe_cyc);
            tag = $sformatf("vec%0d", i);
            $display("vec %0d dut%0d %s addr=%0d data=%h lat=%0d err=%0d prdata=%h", i, vecs[i].dut,
                     vecs[i].wr ? "W" : "R", vecs[i].addr, vecs[i].wdata, lat, resp.pslverr, resp.prdata);
            check({tag, " latency"}, 32'(lat), 32'(vecs[i].exp_lat));
            check({tag, " pslverr"}, 32'(resp.pslverr), 32'(vecs[i].exp_err));
            check({tag, " prdata"}, 32'(resp.prdata), 32'(vecs[i].exp_rdata));
            check({tag, " strobes"}, 32'(strobes), 32'(vecs[i].exp_strobes));
            if (vecs[i].exp_strobes == 1) begin
                check({tag, " strobe cycle"}, 32'(strobe_cyc), 1);
                check({tag, " mem_wr"}, 32'(so.mem_wr), 32'(vecs[i].wr));
                check({tag, " mem_addr"}, 32'(so.mem_addr), 32'(vecs[i].addr));
                check({tag, " mem_write_addr"}, 32'(so.mem_waddr), 32'(vecs[i].addr));
                check({tag, " mem_data_w"}, 32'(so.mem_dw), vecs[i].wr ? 32'(vecs[i].wdata) : 0);
            end
        end

        // psel drops in T+1 of a write: strobe happens, no PREADY, data lands.
        tick();
        xfer(0, 1'b1, 4'd5, 14'h0555, 1, lat, resp, strobes, so, strobe_cyc);
        $display("abort write addr=5 lat=%0d strobes=%0d", lat, strobes);
        check("abort pready", 32'(lat), 0);
        check("abort strobes", 32'(strobes), 1);
        check("abort mem_data_w", 32'(so.mem_dw), 32'h0555);
        tick();
        xfer(0, 1'b0, 4'd5, 14'h0000, 0, lat, resp, strobes, so, strobe_cyc);
        $display("read after abort addr=5 lat=%0d prdata=%h", lat, resp.prdata);
        check("after abort latency", 32'(lat), 3);
        check("after abort prdata", 32'(resp.prdata), 32'h0555);

        // penable without a setup phase is ignored.
        tick();
        psel_a = 1'b1; penable = 1'b1; paddr = 4'd3; pwrite = 1'b0;
        pready_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (pready_a || mem_en_a) pready_seen++;
            @(posedge clk); #1;
        end
        psel_a = 1'b0; penable = 1'b0;
        $display("penable-only in IDLE activity=%0d", pready_seen);
        check("penable-only ignored", 32'(pready_seen), 0);

        // Reset during WAIT of a read on B (RD_LATENCY=3).
        tick();
        psel_b = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 4'd15;
        tick();
        penable = 1'b1;
        tick();
        rst_b = 1'b1;
        #1;
        o = observe(1);
        $display("reset in WAIT outputs=%h", o);
        check("async reset outputs", 32'(o), 0);
        tick();
        rst_b = 1'b0;
        pready_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (pready_b) pready_seen++;
            @(posedge clk); #1;
        end
        psel_b = 1'b0; penable = 1'b0;
        check("no pready after reset", 32'(pready_seen), 0);
        tick();
        xfer(1, 1'b1, 4'd2, 14'h1234, 0, lat, resp, strobes, so, strobe_cyc);
        $display("write after reset addr=2 lat=%0d err=%0d", lat, resp.pslverr);
        check("post-reset write latency", 32'(lat), 2);
        check("post-reset write pslverr", 32'(resp.pslverr), 0);
        check("post-reset write data", 32'(so.mem_dw), 32'h1234);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
